// File: rtl/wavetable_pkg.sv
// Shared types and constants for the wavetable reader: FSM encoding and table geometry.
package wavetable_pkg;

    localparam int TABLE_ADDR_W = 9;
    localparam int SAMPLE_W     = 16;
    localparam int FRAC_W       = 8;
    localparam int RAM_RD_LAT   = 1;

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        CAP,
        OUT
    } wt_state_t;

endpackage

// File: rtl/wt_lerp.sv
// Linear interpolator between two adjacent unsigned table words.
// The result is s0 + floor((s1 - s0) * frac / 256). It always lies between s0 and s1.
module wt_lerp
    import wavetable_pkg::*;
#(
    parameter int DATA_W = SAMPLE_W,
    parameter int FW     = FRAC_W
) (
    input  logic [DATA_W-1:0] s0,
    input  logic [DATA_W-1:0] s1,
    input  logic [FW-1:0]     frac,
    output logic [DATA_W-1:0] sample
);

    localparam int PW = DATA_W + FW + 1;

    logic signed [DATA_W:0] diff;
    logic signed [PW-1:0]   diff_x;
    logic signed [PW-1:0]   frac_x;
    logic signed [PW-1:0]   prod;

    assign diff   = $signed({1'b0, s1}) - $signed({1'b0, s0});
    assign diff_x = PW'(diff);
    assign frac_x = $signed(PW'({1'b0, frac}));
    assign prod   = diff_x * frac_x;

    // The arithmetic shift floors toward minus infinity. Truncating to DATA_W is
    // exact because the sum stays inside the [s0, s1] range.
    assign sample = s0 + DATA_W'(prod >>> FW);

endmodule

// File: rtl/wavetable_reader.sv
// Phase-accumulating wavetable reader. Each request fetches table[idx] and table[idx+1]
// from a 1-cycle-latency RAM and emits one linearly interpolated sample.
module wavetable_reader
    import wavetable_pkg::*;
#(
    parameter int PHASE_W = 24,
    parameter int ADDR_W  = TABLE_ADDR_W,
    parameter int DATA_W  = SAMPLE_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sample_req,
    input  logic [PHASE_W-1:0] phase_inc,
    input  logic               phase_clr,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic [DATA_W-1:0]  ram_wdata,
    output logic               ram_ce,
    output logic               ram_we,
    output logic               ram_re,
    input  logic [DATA_W-1:0]  ram_rdata,
    output logic [DATA_W-1:0]  sample_out,
    output logic               out_valid,
    output logic               busy,
    output logic               overrun
);

    wt_state_t state, next_state;

    logic [PHASE_W-1:0] phase;
    logic [ADDR_W-1:0]  idx, req_idx;
    logic [FRAC_W-1:0]  frac, req_frac;
    logic [DATA_W-1:0]  s0, s1, lerp;
    logic               accept;

    assign ram_wdata = '0;
    assign ram_we    = 1'b0;

    // A clear arriving with the request makes the request read phase 0.
    assign accept   = (state == IDLE) && sample_req;
    assign req_idx  = phase_clr ? '0 : phase[PHASE_W-1 -: ADDR_W];
    assign req_frac = phase_clr ? '0 : phase[PHASE_W-ADDR_W-1 -: FRAC_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (sample_req) next_state = RD0;
            RD0:     next_state = RD1;
            RD1:     next_state = CAP;
            CAP:     next_state = OUT;
            OUT:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    wt_lerp #(.DATA_W(DATA_W), .FW(FRAC_W)) u_lerp (
        .s0     (s0),
        .s1     (s1),
        .frac   (frac),
        .sample (lerp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase      <= '0;
            idx        <= '0;
            frac       <= '0;
            s0         <= '0;
            s1         <= '0;
            ram_addr   <= '0;
            ram_ce     <= 1'b0;
            ram_re     <= 1'b0;
            sample_out <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            overrun   <= sample_req && (state != IDLE);
            busy      <= (next_state != IDLE);

            if (accept)         phase <= phase_clr ? phase_inc : phase + phase_inc;
            else if (phase_clr) phase <= '0;

            // RAM controls are registered on state entry, so the address for a
            // state is already on the bus during that state's cycle.
            case (state)
                IDLE: begin
                    if (sample_req) begin
                        idx      <= req_idx;
                        frac     <= req_frac;
                        ram_addr <= req_idx;
                        ram_ce   <= 1'b1;
                        ram_re   <= 1'b1;
                    end
                end
                RD0: ram_addr <= idx + ADDR_W'(1);
                RD1: begin
                    s0     <= ram_rdata;
                    ram_ce <= 1'b0;
                    ram_re <= 1'b0;
                end
                CAP: s1 <= ram_rdata;
                OUT: begin
                    sample_out <= lerp;
                    out_valid  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wavetable_reader.sv
// Randomized self-checking bench for wavetable_reader against a behavioural RAM and phase model.
module tb_wavetable_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_req = 1'b0;
    logic        phase_clr = 1'b0;
    logic [23:0] phase_inc = '0;
    logic [8:0]  ram_addr;
    logic [15:0] ram_wdata, ram_rdata, sample_out;
    logic        ram_ce, ram_we, ram_re, out_valid, busy, overrun;

    logic [15:0] mem [512];
    int          n_chk = 0;
    int          n_pass = 0;
    int unsigned m_phase = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (ram_ce && ram_re) ram_rdata <= mem[ram_addr];
    end

    wavetable_reader dut (
        .clk(clk), .rst_n(rst_n), .sample_req(sample_req), .phase_inc(phase_inc),
        .phase_clr(phase_clr), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_re(ram_re), .ram_rdata(ram_rdata),
        .sample_out(sample_out), .out_valid(out_valid), .busy(busy), .overrun(overrun)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Expected sample for a given phase, straight from the interpolation rule.
    function automatic logic [15:0] model(input int unsigned ph);
        int idx, fr, a, b, num, q;
        idx = int'((ph >> 15) & 511);
        fr  = int'((ph >> 7) & 255);
        a   = int'(mem[idx]);
        b   = int'(mem[(idx + 1) % 512]);
        num = (b - a) * fr;
        q   = num / 256;
        if (num < 0 && (num % 256) != 0) q--;
        return 16'(a + q);
    endfunction

    task automatic do_req(input logic [23:0] inc, input bit clr, input int dup_at,
                          input int clr_at, input string tag, output logic [15:0] smp);
        int unsigned rd_ph;
        int          idx, nv, vk;
        bit          ov_ok;
        logic [15:0] exp_v;
        rd_ph   = clr ? 0 : m_phase;
        m_phase = clr ? {8'h0, inc} : (m_phase + {8'h0, inc}) & 32'h00FF_FFFF;
        if (clr_at > 0) m_phase = 0;
        idx   = int'((rd_ph >> 15) & 511);
        exp_v = model(rd_ph);
        nv = 0; vk = -1; ov_ok = 1'b1; smp = '0;
        @(negedge clk);
        sample_req = 1'b1; phase_inc = inc; phase_clr = clr;
        @(posedge clk); #1;
        chk({tag, " busy"}, 32'(busy), 1);
        chk({tag, " addr0"}, 32'(ram_addr), idx);
        chk({tag, " ce_re"}, 32'(ram_ce & ram_re), 1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            sample_req = (k == dup_at);
            phase_clr  = (k == clr_at);
            @(posedge clk); #1;
            if (k == 1) chk({tag, " addr1"}, 32'(ram_addr), (idx + 1) % 512);
            if (out_valid) begin nv++; vk = k; smp = sample_out; end
            if (overrun !== 1'(k == dup_at)) ov_ok = 1'b0;
        end
        @(negedge clk);
        sample_req = 1'b0; phase_clr = 1'b0;
        chk({tag, " nvalid"}, nv, 1);
        chk({tag, " latency"}, vk, 4);
        chk({tag, " sample"}, 32'(smp), 32'(exp_v));
        chk({tag, " overrun"}, 32'(ov_ok), 1);
        chk({tag, " idle"}, 32'(busy | ram_ce | ram_we), 0);
    endtask

    initial begin
        logic [15:0] s;
        int          nv, dup;
        logic [23:0] inc;
        bit          clr;

        for (int i = 0; i < 512; i++) mem[i] = 16'(i * 128);

        repeat (2) @(posedge clk);
        #1;
        chk("reset outs", 32'({sample_out, ram_addr, out_valid, busy, overrun, ram_ce, ram_re, ram_we}), 0);
        chk("reset wdata", 32'(ram_wdata), 0);
        @(negedge clk) rst_n = 1'b1;

        // Reset in the middle of a fetch.
        @(negedge clk);
        sample_req = 1'b1; phase_inc = 24'h123456;
        @(posedge clk);
        @(negedge clk) sample_req = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0; #1;
        chk("midrst outs", 32'({sample_out, ram_addr, out_valid, busy, overrun, ram_ce, ram_re}), 0);
        @(negedge clk) rst_n = 1'b1;
        m_phase = 0;
        nv = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) nv++;
        end
        chk("midrst no valid", nv, 0);
        do_req(24'h008000, 1'b0, 0, 0, "post_rst", s);
        chk("post_rst val", 32'(s), 32'h0000);

        // Integer steps, frac 0.
        do_req(24'h008000, 1'b1, 0, 0, "step0", s);
        chk("step0 val", 32'(s), 32'h0000);
        do_req(24'h008000, 1'b0, 0, 0, "step1", s);
        chk("step1 val", 32'(s), 32'h0080);
        do_req(24'h008000, 1'b0, 0, 0, "step2", s);
        chk("step2 val", 32'(s), 32'h0100);

        // Interpolation, rising and falling.
        mem[10] = 16'h1000; mem[11] = 16'h2000;
        do_req(24'h054000, 1'b1, 0, 0, "interp_set", s);
        do_req(24'h000000, 1'b0, 0, 0, "interp_up", s);
        chk("interp_up val", 32'(s), 32'h1800);
        mem[10] = 16'h2000; mem[11] = 16'h1000;
        do_req(24'h052000, 1'b1, 0, 0, "interp_set2", s);
        do_req(24'h000000, 1'b0, 0, 0, "interp_dn", s);
        chk("interp_dn val", 32'(s), 32'h1C00);
        do_req(24'h000000, 1'b0, 0, 0, "inc0_rep", s);
        chk("inc0_rep val", 32'(s), 32'h1C00);

        // Table wrap and phase overflow.
        mem[511] = 16'hE000; mem[0] = 16'h2000;
        do_req(24'hFFC000, 1'b1, 0, 0, "wrap_set", s);
        do_req(24'h008000, 1'b0, 0, 0, "wrap", s);
        chk("wrap val", 32'(s), 32'h8000);
        do_req(24'h000000, 1'b0, 0, 0, "ovf", s);
        chk("ovf val", 32'(s), 32'h1040);

        // Overrun, clear-with-request, clear while busy.
        do_req(24'h008000, 1'b0, 2, 0, "overrun", s);
        do_req(24'h000000, 1'b0, 0, 0, "after_ovr", s);
        do_req(24'h010000, 1'b1, 0, 0, "clr_req", s);
        do_req(24'h000000, 1'b0, 0, 0, "clr_req_nxt", s);
        do_req(24'h008000, 1'b0, 0, 2, "clr_busy", s);
        do_req(24'h000000, 1'b0, 0, 0, "clr_busy_nxt", s);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) mem[$urandom_range(0, 511)] = 16'($urandom);
            inc = 24'($urandom);
            clr = ($urandom_range(0, 7) == 0);
            dup = $urandom_range(0, 3);
            do_req(inc, clr, (dup == 1) ? 2 : (dup == 2) ? 3 : 0, 0, "rnd", s);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/wavetable_reader.md
Name: wavetable_reader

Overview:
Reader side of the 512x16 wavetable RAM interface (9-bit address, ce/we/re, 16-bit data, 1-cycle registered read). Runs a phase accumulator, and on each sample request it fetches two adjacent table words. It linearly interpolates between them and emits one 16-bit unsigned sample with a valid pulse. The block sits between the RAM and the voice/mixer logic of the synthesizer.

Parameters:
PHASE_W, 24, phase accumulator width; index = phase[PHASE_W-1 -: 9], frac = next 8 bits below index
ADDR_W, 9, RAM address width (table length 2^ADDR_W = 512)
DATA_W, 16, sample width (unsigned, offset-binary)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sample_req  in  1  one-cycle pulse requesting the next sample
phase_inc  in  PHASE_W  phase increment, sampled when a request is accepted
phase_clr  in  1  one-cycle pulse, zeroes the phase accumulator
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  tied 16'h0000
ram_ce  out  1  RAM chip enable
ram_we  out  1  tied 0
ram_re  out  1  RAM read enable
ram_rdata  in  DATA_W  RAM read data, valid the cycle after ce&re
sample_out  out  DATA_W  interpolated sample, held until the next out_valid
out_valid  out  1  one-cycle pulse, sample_out updated
busy  out  1  high from acceptance through the out_valid cycle
overrun  out  1  one-cycle pulse when sample_req arrives while busy

Behaviour:
- One clock (clk); reset is asynchronous, active-low (rst_n). Reset clears all outputs, phase and state: sample_out=0, out_valid=0, busy=0, overrun=0, ram_addr=0, ram_ce=0, ram_re=0, state=IDLE.
- All outputs are registered.
- FSM: IDLE -> RD0 -> RD1 -> CAP -> OUT -> IDLE.
- IDLE: on sample_req, latch idx and frac from the current phase, and update phase <= phase + phase_inc (mod 2^PHASE_W). Then go to RD0.
- RD0: ram_addr=idx, ram_ce=ram_re=1.
- RD1: capture s0=ram_rdata. ram_addr=idx+1 (wraps 511->0), ram_ce=ram_re=1.
- CAP: capture s1=ram_rdata. ram_ce=ram_re=0.
- OUT: sample_out = s0 + ((s1 - s0) * frac) >>> 8. The difference is 17-bit signed, the product 25-bit signed, and the shift is arithmetic. The result always lies between s0 and s1 inclusive, so no saturation is needed. out_valid=1 for this cycle, then return to IDLE.
- Latency: a sample_req accepted at edge N gives out_valid high during the cycle after edge N+4.
- ram_ce and ram_re are low in IDLE and OUT; ram_addr holds its last value while idle.
- busy is high in RD0, RD1, CAP and OUT.
- sample_req in any non-IDLE state is dropped, phase does not advance, and overrun pulses the next cycle.
- phase_clr in IDLE together with sample_req: the request reads phase 0 (idx=0, frac=0), then phase <= phase_inc.
- phase_clr alone: phase <= 0.
- phase_clr while busy: phase <= 0 at that edge. The fetch in flight completes with its latched idx/frac.
- frac=0 gives sample_out=s0 exactly. s1 is still fetched.
- phase_inc=0: repeated requests return the same sample.
- Reset asserted mid-fetch: the FSM goes to IDLE immediately and no out_valid is produced. After deassertion the first request reads index 0.

Decomposition:
- Shared package wavetable_pkg holds:
  - FSM state encoding (IDLE, RD0, RD1, CAP, OUT)
  - constants TABLE_ADDR_W=9, SAMPLE_W=16, FRAC_W=8
  - RAM read latency constant RAM_RD_LAT=1
- One sub-module, wt_lerp: combinational/registered interpolator taking s0, s1, frac and producing the sample. It isolates the signed-arithmetic rules for unit checks.
- The accumulator and FSM stay in the top module.

Test Plan:
- The bench drives a behavioural 512x16 RAM model with 1-cycle registered read, preloaded with table[i]=i*16'h0080.
- Reset: hold rst_n=0 mid-fetch -> all outputs 0 at once, state IDLE, no out_valid after release; first request -> ram_addr 0 then 1.
- Integer step: phase_inc=24'h008000, 3 requests spaced 8 cycles -> sample_out 16'h0000, 16'h0080, 16'h0100; out_valid exactly 4 cycles after each request edge.
- Interpolation: table[10]=16'h1000, table[11]=16'h2000, phase=24'h050000+24'h004000 (frac 0x80) -> 16'h1800. Swapped values with frac 0x40 -> 16'h1C00.
- Wrap: phase index 511, frac 0x80, table[511]=16'hE000, table[0]=16'h2000 -> ram_addr sequence 511,0; sample_out 16'h8000. Phase overflow from 24'hFFC000 + 24'h008000 -> 24'h004000.
- Overrun/priority: sample_req again 2 cycles after acceptance -> overrun pulse, exactly one out_valid, phase advanced once. phase_clr+sample_req together -> reads index 0 and phase equals phase_inc afterwards.
